// File: rtl/dispenser_pkg.sv
// Shared definitions for the BCD limit entry block: digit width, FSM
// state encodings and the integer-to-BCD constant conversion.
package dispenser_pkg;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 4;

    // EDIT_i encodes as i so the state doubles as the digit index; RUN sits above every digit.
    typedef enum logic [2:0] {
        ST_EDIT0 = 3'd0,
        ST_EDIT1 = 3'd1,
        ST_EDIT2 = 3'd2,
        ST_EDIT3 = 3'd3,
        ST_RUN   = 3'd4
    } state_e;

    function automatic logic [BCD_W*MAX_DIGITS-1:0] int_to_bcd(input int value);
        logic [BCD_W*MAX_DIGITS-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            r[i*BCD_W +: BCD_W] = BCD_W'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_updn.sv
// One BCD digit with wrap-around increment/decrement; no carry or borrow
// leaves the digit. Simultaneous up and down cancel.
module bcd_digit_updn
    import dispenser_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             down_i,
    output logic [BCD_W-1:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (en_i && up_i && !down_i) begin
            digit_o = (digit_i >= 4'd9) ? 4'd0 : digit_i + 4'd1;
        end else if (en_i && down_i && !up_i) begin
            digit_o = (digit_i == 4'd0) ? 4'd9 : digit_i - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_limit_entry.sv
// Three-button BCD limit editor: step through the digits with btn_state,
// adjust each with btn_up/btn_down, and commit (clamped to MAX_VALUE) on entering RUN.
module bcd_limit_entry
    import dispenser_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter int MAX_VALUE   = 99,
    parameter int RESET_VALUE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_state,
    input  logic                  btn_up,
    input  logic                  btn_down,
    output logic [BCD_W*DIGITS-1:0] limite,
    output logic [BCD_W*DIGITS-1:0] edit_value,
    output logic [2:0]            edit_digit,
    output logic                  enable,
    output logic                  commit,
    output logic                  clamped
);

    localparam int W = BCD_W * DIGITS;
    localparam logic [W-1:0] MAX_BCD   = W'(int_to_bcd(MAX_VALUE));
    localparam logic [W-1:0] RESET_BCD = W'(int_to_bcd(RESET_VALUE));
    localparam state_e       LAST_EDIT = state_e'(3'(DIGITS - 1));

    state_e         state_q, state_d;
    logic [2:0]     btn_prev_q, btn_prev_d;
    logic [W-1:0]   edit_q, edit_d;
    logic [W-1:0]   limite_q, limite_d;
    logic           commit_q, commit_d;
    logic           clamped_q, clamped_d;

    logic           ev_state, ev_up, ev_down;
    logic [W-1:0]   edit_upd;
    logic [DIGITS-1:0] digit_en;

    assign ev_state = btn_state & ~btn_prev_q[0];
    assign ev_up    = btn_up    & ~btn_prev_q[1];
    assign ev_down  = btn_down  & ~btn_prev_q[2];

    // A state event suppresses every digit so it wins over a coincident up/down.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign digit_en[g] = (state_q == state_e'(3'(g))) && !ev_state;

        bcd_digit_updn u_digit (
            .digit_i (edit_q[g*BCD_W +: BCD_W]),
            .en_i    (digit_en[g]),
            .up_i    (ev_up),
            .down_i  (ev_down),
            .digit_o (edit_upd[g*BCD_W +: BCD_W])
        );
    end

    always_comb begin
        state_d    = state_q;
        btn_prev_d = {btn_down, btn_up, btn_state};
        edit_d     = edit_upd;
        limite_d   = limite_q;
        commit_d   = 1'b0;
        clamped_d  = 1'b0;
        if (ev_state) begin
            edit_d = edit_q;
            if (state_q == ST_RUN) begin
                state_d = ST_EDIT0;
                edit_d  = limite_q;
            end else if (state_q == LAST_EDIT) begin
                state_d  = ST_RUN;
                commit_d = 1'b1;
                // Valid BCD orders like the integer it encodes, so compare directly.
                if (edit_q > MAX_BCD) begin
                    limite_d  = MAX_BCD;
                    clamped_d = 1'b1;
                end else begin
                    limite_d = edit_q;
                end
                edit_d = limite_d;
            end else begin
                state_d = state_e'(state_q + 3'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EDIT0;
            btn_prev_q <= 3'b111;
            edit_q     <= RESET_BCD;
            limite_q   <= RESET_BCD;
            commit_q   <= 1'b0;
            clamped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_prev_q <= btn_prev_d;
            edit_q     <= edit_d;
            limite_q   <= limite_d;
            commit_q   <= commit_d;
            clamped_q  <= clamped_d;
        end
    end

    assign limite     = limite_q;
    assign edit_value = edit_q;
    assign enable     = (state_q == ST_RUN);
    assign edit_digit = (state_q == ST_RUN) ? 3'(DIGITS) : state_q;
    assign commit     = commit_q;
    assign clamped    = clamped_q;

endmodule
